// File: rtl/display_pkg.sv
// Shared types and the hex to 7-segment table for the display drivers.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package display_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Full hex glyph set, active-low.
    function automatic seg7_t hex_to_seg7(input nibble_t value);
        seg7_t seg;
        unique case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_decoder
    import display_pkg::*;
(
    input  nibble_t nibble,
    output seg7_t   seg
);

    // Pure table lookup.
    always_comb begin
        seg = hex_to_seg7(nibble);
    end

endmodule

// File: rtl/display_scan_driver.sv
// Self-timed multiplexed 7-segment driver: refresh prescaler, digit scan
// index and a registered output stage with blanking, decimal points and
// a scan enable.
// Optional feature: define DISPLAY_LZ_BLANK_EN for leading-zero suppression.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned IDX_W       = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic [N_DIGITS-1:0]   an,
    output seg7_t                 seg,
    output logic                  dp,
    output nibble_t               disp,
    output logic                  slot_tick
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0]    prescaler_q;
    logic [IDX_W-1:0]    idx_q;
    logic                tick;
    nibble_t             dig [N_DIGITS];
    logic [N_DIGITS-1:0] lz_blank;
    nibble_t             cur_nib;
    seg7_t               cur_seg;
    logic                lit;
    logic [N_DIGITS-1:0] an_d;
    seg7_t               seg_d;
    logic                dp_d;

    // Unpack the nibble bus so the scan index can select a digit directly.
    always_comb begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            dig[i] = digits[4*i +: 4];
        end
    end

`ifdef DISPLAY_LZ_BLANK_EN
    logic suppress;

    // Walk down from the top digit; the first nonzero digit or set dp ends suppression.
    always_comb begin
        lz_blank = '0;
        suppress = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            if (suppress && (dig[i] == 4'h0) && !dp_mask[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                suppress = 1'b0;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Slot boundary: prescaler at terminal count while scanning.
    assign tick = enable && (prescaler_q == PRE_MAX);

    // Prescaler and digit index advance only while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            idx_q       <= '0;
        end else if (enable) begin
            if (tick) begin
                prescaler_q <= '0;
                idx_q       <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                prescaler_q <= prescaler_q + PRE_W'(1);
            end
        end
    end

    seg7_decoder u_seg7_decoder (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Next output values from the current index; blanked digits keep their slot.
    always_comb begin
        cur_nib = dig[idx_q];
        lit     = enable && !(blank_mask[idx_q] || lz_blank[idx_q]);
        an_d    = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg;
            dp_d        = ~dp_mask[idx_q];
        end
    end

    // Registered pin stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an        <= '1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            disp      <= '0;
            slot_tick <= 1'b0;
        end else begin
            an        <= an_d;
            seg       <= seg_d;
            dp        <= dp_d;
            disp      <= cur_nib;
            slot_tick <= tick;
        end
    end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Parametrised, self-timed successor to the combinational 8-digit display multiplexer.
- Holds its own refresh prescaler and digit scan counter.
- Selects one nibble per slot, decodes it to active-low 7-segment levels, and drives a one-hot-low anode.
- Adds per-digit blanking, per-digit decimal points and a scan enable.
- Sits between the datapath's digit registers and the board's seg/an/dp pins.

Parameters:
- N_DIGITS, 8, number of multiplexed digits; legal range 2..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥2. Default gives 1 kHz per slot at 100 MHz.
- IDX_W, $clog2(N_DIGITS), derived width of the digit index. Not overridden by users.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low blanks all digits and freezes the scan.
- digits  in  4*N_DIGITS  packed nibbles; digit i is digits[4*i+3:4*i].
- blank_mask  in  N_DIGITS  bit i=1 forces digit i dark.
- dp_mask  in  N_DIGITS  bit i=1 lights the decimal point of digit i.
- an  out  N_DIGITS  anode enables, active-low, at most one bit low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- disp  out  4  nibble currently shown, for debug/compat.
- slot_tick  out  1  one-cycle pulse when the index advances.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - prescaler=0, idx=0
  - an=all ones, seg=7'h7F, dp=1, disp=0, slot_tick=0
- Prescaler:
  - When enable=1: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and asserts an internal tick.
  - When enable=0: holds its value.
- Index:
  - On tick, idx advances by 1.
  - idx=N_DIGITS-1 wraps to 0. N_DIGITS need not be a power of two; idx never reaches N_DIGITS.
- slot_tick: registered copy of tick, high exactly one cycle, one cycle after the prescaler wrap.
- Output stage is registered, recomputed every cycle from the current idx, digits, blank_mask, dp_mask and enable:
  - 1-cycle latency from any input or idx change to an/seg/dp/disp.
  - disp = digit[idx].
  - an = ~(1<<idx) when enable=1 and blank_mask[idx]=0; otherwise all ones.
  - seg = decode(digit[idx]) when that digit is lit; otherwise 7'h7F.
  - dp = ~dp_mask[idx] when that digit is lit; otherwise 1.
- Decode covers full hex 0-F: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E, etc. (g..a ordering).
- Blanked digits still consume their slot, so the duty cycle of the lit digits is unchanged.
- enable 1→0: within one cycle an=all ones, seg=7'h7F, dp=1; idx and prescaler freeze. enable 0→1 resumes from the frozen state, with no extra tick.
- Input changes mid-slot are visible on the next cycle; there is no slot-boundary sampling.
- Reset mid-slot: immediate blank, restart at idx 0, first tick REFRESH_DIV cycles after reset release.

Optional Feature:
- Macro: DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero suppression. A digit i>0 is auto-blanked if it and every digit above it are 0. Digit 0 is never auto-blanked. Auto-blank is ORed with blank_mask. A digit whose dp_mask bit is set is not auto-blanked, and it stops suppression of all lower digits.
- Undefined: no suppression; only blank_mask blanks.

Decomposition:
- Package display_pkg:
  - SEG_BLANK=7'h7F
  - typedef logic [3:0] nibble_t
  - typedef logic [6:0] seg7_t
  - function or constant table for hex→seg7.
- Sub-module seg7_decoder: combinational nibble_t in → seg7_t out, reusable elsewhere. Prescaler, index and output registers stay in display_scan_driver.

Test Plan:
- Sims use N_DIGITS=8, REFRESH_DIV=4.
- Reset then release, digits=32'h76543210: an steps FE,FD,FB,…,7F and wraps to FE. Each an value lasts 4 cycles. seg matches digit 0..7. slot_tick pulses every 4 cycles.
- N_DIGITS=5, REFRESH_DIV=3: an cycles 1E,1D,1B,17,0F,1E. idx never exceeds 4.
- blank_mask=8'h0A, dp_mask=8'h01: during slots 1 and 3 an=FF and seg=7F. During slot 0 dp=0; in all other slots dp=1. Slot timing unchanged.
- enable dropped in mid-slot 2 for 10 cycles: next cycle an=FF, slot_tick silent. After re-enable, slot 2 finishes its remaining count, then slot 3 starts.
- reset asserted asynchronously mid-slot 5: outputs blank without waiting for clk. After release, slot 0 begins and the first slot_tick comes 4 cycles later.
- With DISPLAY_LZ_BLANK_EN, digits=32'h00000120, dp_mask=0: digits 3..7 dark, digits 0..2 lit. Set dp_mask=8'h40: digits 0..6 lit, digit 7 dark.
